rx_payload_deq_arb: RTL and testbench

RX_PAYLOAD_DEQ_ARB -- requirements
Module: rx_payload_deq_arb

---
 rtl/rx_payload_deq_arb_if.sv | 53 +++++
 rtl/rx_payload_deq_arb.sv | 179 +++++++++++++++++
 tb/tb_rx_payload_deq_arb.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_payload_deq_arb_if.sv
`default_nettype none

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_ENTRY_W
`define PAYLOAD_ENTRY_W 32
`endif

// ============================================================================
// Module   : rx_payload_deq_arb_if
// Purpose  : Request/response link between the payload-read arbiter and the
//            RX payload dequeue pipeline.
// Signals  : read_payload_req_val/flowid/rdy   - request channel (arb -> pipe)
//            read_payload_resp_val/is_empty/entry/rdy - response channel
//                                               (pipe -> arb), in request order
// Modports : master - arbiter side; slave - dequeue pipeline side
// Revision : 1.0 - initial release
// ============================================================================
interface rx_payload_deq_arb_if;

  logic                        read_payload_req_val;
  logic [`FLOW_ID_W-1:0]       read_payload_req_flowid;
  logic                        read_payload_req_rdy;

  logic                        read_payload_resp_val;
  logic                        read_payload_resp_is_empty;
  logic [`PAYLOAD_ENTRY_W-1:0] read_payload_resp_entry;
  logic                        read_payload_resp_rdy;

  modport master (
    output read_payload_req_val,
    output read_payload_req_flowid,
    input  read_payload_req_rdy,
    input  read_payload_resp_val,
    input  read_payload_resp_is_empty,
    input  read_payload_resp_entry,
    output read_payload_resp_rdy
  );

  modport slave (
    input  read_payload_req_val,
    input  read_payload_req_flowid,
    output read_payload_req_rdy,
    output read_payload_resp_val,
    output read_payload_resp_is_empty,
    output read_payload_resp_entry,
    input  read_payload_resp_rdy
  );

endinterface

`default_nettype wire

// File: rtl/rx_payload_deq_arb.sv
`default_nettype none

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_ENTRY_W
`define PAYLOAD_ENTRY_W 32
`endif

// ============================================================================
// Module   : rx_payload_deq_arb
// Purpose  : Round-robin arbiter that shares one RX payload dequeue pipeline
//            among NUM_REQ requesters. Granted requester indices are kept in
//            a small tag FIFO so the in-order responses can be steered back
//            to the requester that issued them. No cycles are added on either
//            path; one request and one response can complete every cycle.
// Ports    : clk           - clock, all state on rising edge
//            rst           - asynchronous reset, active low
//            req_val       - per-requester request valid
//            req_flowid    - packed flow IDs, requester i in slice i
//            req_rdy       - per-requester request accepted
//            resp_val      - per-requester response valid (one-hot or zero)
//            resp_is_empty - shared queue-was-empty flag for the response
//            resp_entry    - shared payload entry for the response
//            resp_rdy      - per-requester response ready
//            rp            - link to the dequeue pipeline (master side)
// Revision : 1.0 - initial release
// ============================================================================
module rx_payload_deq_arb #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_val,
  input  logic [NUM_REQ*`FLOW_ID_W-1:0]    req_flowid,
  output logic [NUM_REQ-1:0]               req_rdy,
  output logic [NUM_REQ-1:0]               resp_val,
  output logic                             resp_is_empty,
  output logic [`PAYLOAD_ENTRY_W-1:0]      resp_entry,
  input  logic [NUM_REQ-1:0]               resp_rdy,
  rx_payload_deq_arb_if.master             rp
);

  localparam int c_REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_TAG_PTR_W = $clog2(TAG_DEPTH);
  localparam int c_CNT_W     = c_TAG_PTR_W + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_REQ_IDX_W-1:0] r_rr_ptr;
  logic [c_REQ_IDX_W-1:0] r_tag_mem [TAG_DEPTH];
  logic [c_TAG_PTR_W-1:0] r_wr_ptr;
  logic [c_TAG_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]     r_count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [`FLOW_ID_W-1:0]  w_flowid [NUM_REQ];
  logic                   w_any;
  logic [c_REQ_IDX_W-1:0] w_grant_idx;
  logic [NUM_REQ-1:0]     w_grant;
  logic [c_REQ_IDX_W-1:0] w_rr_next;
  logic                   w_tag_full;
  logic                   w_tag_empty;
  logic                   w_req_ok;
  logic                   w_resp_ok;
  logic                   w_push;
  logic                   w_pop;
  logic [c_REQ_IDX_W-1:0] w_head;

  // Unpack the flat flow-ID bus into one slot per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_flowid_unpack
      assign w_flowid[gi] = req_flowid[gi*`FLOW_ID_W +: `FLOW_ID_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin grant: scan from r_rr_ptr upward, wrapping at NUM_REQ-1.
  // The sum carries one extra bit so the wrap works for any NUM_REQ, not
  // only powers of two.
  // --------------------------------------------------------------------------
  always_comb begin : p_grant
    logic [c_REQ_IDX_W:0] w_sum;
    w_sum       = '0;
    w_any       = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_REQ_IDX_W+1)'(k);
      if (w_sum >= (c_REQ_IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (c_REQ_IDX_W+1)'(NUM_REQ);
      end
      if (!w_any && req_val[w_sum[c_REQ_IDX_W-1:0]]) begin
        w_any       = 1'b1;
        w_grant_idx = w_sum[c_REQ_IDX_W-1:0];
      end
    end
  end

  assign w_grant   = w_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign w_rr_next = (w_grant_idx == c_REQ_IDX_W'(NUM_REQ-1)) ? '0
                                                              : w_grant_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Tag FIFO status. Full is taken from the registered count only, so a pop
  // in the same cycle never lets a new request slip in while full.
  // --------------------------------------------------------------------------
  assign w_tag_full  = (r_count == c_CNT_W'(TAG_DEPTH));
  assign w_tag_empty = (r_count == '0);
  assign w_head      = r_tag_mem[r_rd_ptr];

  // rst is folded in so every handshake output drops the instant reset is
  // asserted, without waiting for the asynchronous clear to reach the flops.
  assign w_req_ok  = rst & ~w_tag_full;
  assign w_resp_ok = rst & ~w_tag_empty;

  // --------------------------------------------------------------------------
  // Request path
  // --------------------------------------------------------------------------
  assign rp.read_payload_req_val    = w_req_ok & w_any;
  assign rp.read_payload_req_flowid = w_any ? w_flowid[w_grant_idx] : '0;
  assign req_rdy                    = w_grant & {NUM_REQ{w_req_ok & rp.read_payload_req_rdy}};
  assign w_push                     = rp.read_payload_req_val & rp.read_payload_req_rdy;

  // --------------------------------------------------------------------------
  // Response path: steered to the requester at the tag FIFO head. A stalled
  // head requester stalls the pipeline, keeping responses strictly in order.
  // --------------------------------------------------------------------------
  assign resp_val = (w_resp_ok & rp.read_payload_resp_val) ? (NUM_REQ'(1) << w_head) : '0;
  assign rp.read_payload_resp_rdy = w_resp_ok & resp_rdy[w_head];
  assign resp_is_empty            = rp.read_payload_resp_is_empty;
  assign resp_entry               = rp.read_payload_resp_entry;
  assign w_pop                    = rp.read_payload_resp_val & rp.read_payload_resp_rdy;

  // --------------------------------------------------------------------------
  // Round-robin pointer: advances past the winner only on an accepted request.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Tag FIFO storage and pointers. Power-of-two depth lets the pointers wrap
  // naturally; the count is one bit wider to distinguish full from empty.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        r_tag_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= w_grant_idx;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_payload_deq_arb.sv
`default_nettype none

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_ENTRY_W
`define PAYLOAD_ENTRY_W 32
`endif

// ============================================================================
// Module   : tb_rx_payload_deq_arb
// Purpose  : Self-checking bench for rx_payload_deq_arb. A small in-order
//            dequeue-pipeline model answers accepted requests; expected
//            accepts and responses are queued as stimulus is applied and
//            compared as the design produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_payload_deq_arb;

  localparam int NUM_REQ   = 4;
  localparam int TAG_DEPTH = 4;
  localparam int FW        = `FLOW_ID_W;
  localparam int EW        = `PAYLOAD_ENTRY_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_val;
  logic [NUM_REQ*FW-1:0] req_flowid;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [NUM_REQ-1:0]    resp_val;
  logic                  resp_is_empty;
  logic [EW-1:0]         resp_entry;
  logic [NUM_REQ-1:0]    resp_rdy;

  rx_payload_deq_arb_if bus ();

  rx_payload_deq_arb #(
    .NUM_REQ   (NUM_REQ),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_val       (req_val),
    .req_flowid    (req_flowid),
    .req_rdy       (req_rdy),
    .resp_val      (resp_val),
    .resp_is_empty (resp_is_empty),
    .resp_entry    (resp_entry),
    .resp_rdy      (resp_rdy),
    .rp            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [FW-1:0] flow;
  } acc_t;

  typedef struct {
    int            idx;
    logic [EW-1:0] entry;
    logic          empty;
  } rsp_t;

  acc_t          exp_acc[$];
  rsp_t          exp_rsp[$];
  logic [FW-1:0] pipe_q[$];
  bit            resp_en;
  int            n_checks = 0;
  int            n_pass   = 0;

  // Pipeline model contents: flow 0x3E reports an empty queue with zero entry.
  function automatic logic empty_of(logic [FW-1:0] f);
    return (f == 8'h3E);
  endfunction

  function automatic logic [EW-1:0] entry_of(logic [FW-1:0] f);
    if (f == 8'h3E) return '0;
    return EW'({24'hC0FFEE, f});
  endfunction

  function automatic int onehot_idx(logic [NUM_REQ-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_flow(int i, logic [FW-1:0] f);
    req_flowid[i*FW +: FW] = f;
  endtask

  task automatic drive_ds();
    if (resp_en && pipe_q.size() > 0) begin
      bus.read_payload_resp_val      = 1'b1;
      bus.read_payload_resp_is_empty = empty_of(pipe_q[0]);
      bus.read_payload_resp_entry    = entry_of(pipe_q[0]);
    end else begin
      bus.read_payload_resp_val      = 1'b0;
      bus.read_payload_resp_is_empty = 1'b0;
      bus.read_payload_resp_entry    = '0;
    end
  endtask

  task automatic expect_txn(int idx, logic [FW-1:0] f);
    acc_t a;
    rsp_t r;
    a.idx = idx; a.flow = f;
    r.idx = idx; r.entry = entry_of(f); r.empty = empty_of(f);
    exp_acc.push_back(a);
    exp_rsp.push_back(r);
  endtask

  // One clock: observe handshakes just before the edge, then update the
  // pipeline model outputs just after it.
  task automatic step();
    int            idx;
    acc_t          a;
    rsp_t          r;
    logic [FW-1:0] dropped;
    @(negedge clk);
    if (bus.read_payload_resp_val && bus.read_payload_resp_rdy) begin
      idx = onehot_idx(resp_val);
      n_checks++;
      if (exp_rsp.size() == 0) begin
        $display("FAIL rsp_unexpected: got requester %0d, required no response", idx);
      end else begin
        r = exp_rsp.pop_front();
        if (idx !== r.idx || resp_entry !== r.entry || resp_is_empty !== r.empty)
          $display("FAIL rsp_order: got req %0d entry %h empty %0b, required req %0d entry %h empty %0b",
                   idx, resp_entry, resp_is_empty, r.idx, r.entry, r.empty);
        else
          n_pass++;
      end
      dropped = pipe_q.pop_front();
    end
    if (bus.read_payload_req_val && bus.read_payload_req_rdy) begin
      idx = onehot_idx(req_rdy);
      n_checks++;
      if (exp_acc.size() == 0) begin
        $display("FAIL acc_unexpected: got requester %0d flow %0d, required no accept",
                 idx, bus.read_payload_req_flowid);
      end else begin
        a = exp_acc.pop_front();
        if (idx !== a.idx || bus.read_payload_req_flowid !== a.flow)
          $display("FAIL acc_order: got req %0d flow %0d, required req %0d flow %0d",
                   idx, bus.read_payload_req_flowid, a.idx, a.flow);
        else
          n_pass++;
      end
      pipe_q.push_back(bus.read_payload_req_flowid);
    end
    @(posedge clk);
    #1;
    drive_ds();
  endtask

  task automatic drain(string name);
    req_val = '0;
    for (int i = 0; i < 40 && (exp_acc.size() > 0 || exp_rsp.size() > 0); i++) step();
    n_checks++;
    if (exp_acc.size() == 0 && exp_rsp.size() == 0)
      n_pass++;
    else
      $display("FAIL drain_%s: got %0d accepts / %0d responses outstanding, required 0/0",
               name, exp_acc.size(), exp_rsp.size());
  endtask

  task automatic apply_reset();
    rst     = 1'b0;
    req_val = '0;
    resp_en = 1'b0;
    exp_acc.delete();
    exp_rsp.delete();
    pipe_q.delete();
    drive_ds();
    bus.read_payload_req_rdy = 1'b1;
    resp_rdy = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_val = '1;
    for (int i = 0; i < NUM_REQ; i++) set_flow(i, FW'(i + 1));
    bus.read_payload_req_rdy = 1'b1;
    resp_rdy = '1;
    bus.read_payload_resp_val = 1'b1;
    #3;
    n_checks++;
    if (bus.read_payload_req_val !== 1'b0 || req_rdy !== '0)
      $display("FAIL reset_req: got req_val %0b req_rdy %b, required 0 0000",
               bus.read_payload_req_val, req_rdy);
    else n_pass++;
    n_checks++;
    if (resp_val !== '0 || bus.read_payload_resp_rdy !== 1'b0)
      $display("FAIL reset_resp: got resp_val %b resp_rdy %0b, required 0000 0",
               resp_val, bus.read_payload_resp_rdy);
    else n_pass++;
    bus.read_payload_resp_val = 1'b0;
    apply_reset();
    req_val = '1;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0001 || bus.read_payload_req_flowid !== FW'(1) ||
        bus.read_payload_resp_rdy !== 1'b0)
      $display("FAIL reset_first_grant: got req_rdy %b flow %0d resp_rdy %0b, required 0001 1 0",
               req_rdy, bus.read_payload_req_flowid, bus.read_payload_resp_rdy);
    else n_pass++;
    req_val = '0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_flow(i, FW'(10 + i));
    resp_en = 1'b1;
    req_val = '1;
    expect_txn(0, 8'd10);
    expect_txn(1, 8'd11);
    expect_txn(2, 8'd12);
    expect_txn(3, 8'd13);
    expect_txn(0, 8'd10);
    repeat (5) step();
    drain("round_robin");
  endtask

  task automatic test_stall();
    apply_reset();
    set_flow(0, 8'd20);
    set_flow(2, 8'd22);
    set_flow(3, 8'd23);
    resp_en = 1'b1;
    req_val = 4'b0100;
    bus.read_payload_req_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_rdy !== '0 || bus.read_payload_req_val !== 1'b1 ||
          bus.read_payload_req_flowid !== 8'd22)
        $display("FAIL stall_hold: got req_rdy %b val %0b flow %0d, required 0000 1 22",
                 req_rdy, bus.read_payload_req_val, bus.read_payload_req_flowid);
      else n_pass++;
      step();
    end
    // Pointer must still be 0: requester 0 wins over 2 and 3.
    req_val = 4'b1101;
    #1;
    n_checks++;
    if (bus.read_payload_req_flowid !== 8'd20)
      $display("FAIL stall_ptr_hold: got flow %0d, required 20", bus.read_payload_req_flowid);
    else n_pass++;
    req_val = 4'b0100;
    bus.read_payload_req_rdy = 1'b1;
    expect_txn(2, 8'd22);
    #1;
    n_checks++;
    if (req_rdy !== 4'b0100)
      $display("FAIL stall_accept: got req_rdy %b, required 0100", req_rdy);
    else n_pass++;
    step();
    // Pointer is now 3: requester 3 wins when all request.
    bus.read_payload_req_rdy = 1'b0;
    req_val = '1;
    #1;
    n_checks++;
    if (bus.read_payload_req_flowid !== 8'd23)
      $display("FAIL stall_ptr_next: got flow %0d, required 23", bus.read_payload_req_flowid);
    else n_pass++;
    bus.read_payload_req_rdy = 1'b1;
    expect_txn(3, 8'd23);
    step();
    drain("stall");
  endtask

  task automatic test_full();
    apply_reset();
    resp_en = 1'b0;
    req_val = 4'b0001;
    for (int k = 0; k < TAG_DEPTH; k++) begin
      set_flow(0, FW'(40 + k));
      expect_txn(0, FW'(40 + k));
      step();
    end
    set_flow(0, 8'd44);
    #1;
    n_checks++;
    if (bus.read_payload_req_val !== 1'b0 || req_rdy !== '0)
      $display("FAIL full_block: got val %0b req_rdy %b, required 0 0000",
               bus.read_payload_req_val, req_rdy);
    else n_pass++;
    step();
    resp_en = 1'b1;
    drive_ds();
    #1;
    n_checks++;
    if (bus.read_payload_resp_rdy !== 1'b1 || bus.read_payload_req_val !== 1'b0)
      $display("FAIL full_no_bypass: got resp_rdy %0b req_val %0b, required 1 0",
               bus.read_payload_resp_rdy, bus.read_payload_req_val);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (bus.read_payload_req_val !== 1'b1 || req_rdy !== 4'b0001)
      $display("FAIL full_release: got val %0b req_rdy %b, required 1 0001",
               bus.read_payload_req_val, req_rdy);
    else n_pass++;
    expect_txn(0, 8'd44);
    step();
    drain("full");
  endtask

  task automatic test_hol();
    apply_reset();
    resp_en  = 1'b1;
    resp_rdy = 4'b1000;
    set_flow(1, 8'd51);
    set_flow(3, 8'd53);
    req_val = 4'b0010;
    expect_txn(1, 8'd51);
    step();
    req_val = 4'b1000;
    expect_txn(3, 8'd53);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (resp_val !== 4'b0010 || bus.read_payload_resp_rdy !== 1'b0)
        $display("FAIL hol_stall: got resp_val %b resp_rdy %0b, required 0010 0",
                 resp_val, bus.read_payload_resp_rdy);
      else n_pass++;
      step();
      req_val = '0;
    end
    resp_rdy = 4'b1010;
    #1;
    n_checks++;
    if (bus.read_payload_resp_rdy !== 1'b1)
      $display("FAIL hol_release: got resp_rdy %0b, required 1", bus.read_payload_resp_rdy);
    else n_pass++;
    step();
    drain("hol");
  endtask

  task automatic test_empty_flag();
    apply_reset();
    resp_en = 1'b1;
    set_flow(3, 8'h3E);
    req_val = 4'b1000;
    expect_txn(3, 8'h3E);
    step();
    req_val = '0;
    #1;
    n_checks++;
    if (resp_val !== 4'b1000 || resp_is_empty !== 1'b1 || resp_entry !== '0 ||
        bus.read_payload_resp_rdy !== 1'b1)
      $display("FAIL empty_flag: got resp_val %b empty %0b entry %h rdy %0b, required 1000 1 0 1",
               resp_val, resp_is_empty, resp_entry, bus.read_payload_resp_rdy);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (bus.read_payload_resp_rdy !== 1'b0 || resp_val !== '0)
      $display("FAIL empty_popped: got resp_rdy %0b resp_val %b, required 0 0000",
               bus.read_payload_resp_rdy, resp_val);
    else n_pass++;
    drain("empty_flag");
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_flow(i, FW'(60 + i));
    req_val = '1;
    expect_txn(0, 8'd60);
    expect_txn(1, 8'd61);
    expect_txn(2, 8'd62);
    repeat (3) step();
    resp_en = 1'b1;
    drive_ds();
    #1;
    n_checks++;
    if (resp_val !== 4'b0001 || bus.read_payload_req_val !== 1'b1)
      $display("FAIL pre_reset: got resp_val %b req_val %0b, required 0001 1",
               resp_val, bus.read_payload_req_val);
    else n_pass++;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.read_payload_req_val !== 1'b0 || req_rdy !== '0 || resp_val !== '0 ||
        bus.read_payload_resp_rdy !== 1'b0)
      $display("FAIL async_reset_outputs: got req_val %0b req_rdy %b resp_val %b resp_rdy %0b, required all 0",
               bus.read_payload_req_val, req_rdy, resp_val, bus.read_payload_resp_rdy);
    else n_pass++;
    // The dequeue pipeline is reset by the same signal.
    exp_acc.delete();
    exp_rsp.delete();
    pipe_q.delete();
    drive_ds();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0001 || bus.read_payload_req_flowid !== 8'd60 ||
        bus.read_payload_resp_rdy !== 1'b0)
      $display("FAIL post_reset_grant: got req_rdy %b flow %0d resp_rdy %0b, required 0001 60 0",
               req_rdy, bus.read_payload_req_flowid, bus.read_payload_resp_rdy);
    else n_pass++;
    expect_txn(0, 8'd60);
    step();
    drain("async_reset");
  endtask

  initial begin
    rst        = 1'b0;
    req_val    = '0;
    req_flowid = '0;
    resp_rdy   = '0;
    resp_en    = 1'b0;
    bus.read_payload_req_rdy       = 1'b0;
    bus.read_payload_resp_val      = 1'b0;
    bus.read_payload_resp_is_empty = 1'b0;
    bus.read_payload_resp_entry    = '0;
    test_reset();
    test_round_robin();
    test_stall();
    test_full();
    test_hol();
    test_empty_flag();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
